// File: rtl/pm_ctrl_acc_pkg.sv
// rtl/pm_ctrl_acc_pkg.sv - shared types and length helpers for the power-monitor register sequencer
package pm_ctrl_acc_pkg;

  localparam int CTRL_LEN_DEF = 16;
  localparam int REF_LEN_DEF  = 32;
  localparam int STAT_LEN_DEF = 32;

  typedef enum logic [1:0] {
    TGT_CTRL = 2'd0,
    TGT_REF  = 2'd1,
    TGT_STAT = 2'd2,
    TGT_ILL  = 2'd3
  } tgt_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SHIFT,
    ST_UPDATE,
    ST_RESP
  } state_e;

  function automatic int tgt_len(tgt_e t, int ctrl_len, int ref_len, int stat_len);
    case (t)
      TGT_CTRL: return ctrl_len;
      TGT_REF:  return ref_len;
      TGT_STAT: return stat_len;
      default:  return 1;
    endcase
  endfunction

endpackage

// File: rtl/pm_ctrl_acc_shifter.sv
// rtl/pm_ctrl_acc_shifter.sv - bit counter with write-bit select and LSB-first read capture
module pm_ctrl_acc_shifter
  import pm_ctrl_acc_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          clr_cnt_i,
  input  logic          shift_i,
  input  logic          sample_i,
  input  logic          so_i,
  input  logic [CW-1:0] len_i,
  output logic          wbit_o,
  output logic          last_o,
  output logic [DW-1:0] rdata_o
);

  localparam int IW = (DW > 1) ? $clog2(DW) : 1;

  logic [CW-1:0] cnt_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [IW-1:0] idx;

  assign idx     = IW'(cnt_q);
  assign wbit_o  = wdata_q[idx];
  assign last_o  = (cnt_q == len_i - 1'b1);
  assign rdata_o = rdata_q;

  // Counter parks at LEN-1; bits above LEN are never written, so rdata stays zero-padded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (load_i) begin
      cnt_q   <= '0;
      wdata_q <= wdata_i;
      rdata_q <= '0;
    end else begin
      if (clr_cnt_i)
        cnt_q <= '0;
      else if (shift_i && !last_o)
        cnt_q <= cnt_q + 1'b1;
      if (sample_i)
        rdata_q[idx] <= so_i;
    end
  end

endmodule

// File: rtl/pm_ctrl_reg_access_seq.sv
// rtl/pm_ctrl_reg_access_seq.sv - word request to serial capture/shift/update sequencer (option: PM_ACC_READBACK_EN)
module pm_ctrl_reg_access_seq
  import pm_ctrl_acc_pkg::*;
#(
  parameter int CTRL_LEN = CTRL_LEN_DEF,
  parameter int REF_LEN  = REF_LEN_DEF,
  parameter int STAT_LEN = STAT_LEN_DEF,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [1:0]    req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          serial_in,
  output logic          capture,
  output logic          shift,
  output logic          write,
  output logic          update,
  output logic          sensor_ctrl_select,
  output logic          ref_counter_select,
  output logic          sensor_status_select,
  input  logic          sensor_ctrl_so,
  input  logic          ref_counter_so,
  input  logic          sensor_status_so
);

  localparam int MAXL = (CTRL_LEN > REF_LEN) ? ((CTRL_LEN > STAT_LEN) ? CTRL_LEN : STAT_LEN)
                                             : ((REF_LEN > STAT_LEN) ? REF_LEN : STAT_LEN);
  localparam int CW   = $clog2(MAXL) + 1;

  state_e        state_q;
  tgt_e          tgt_q;
  logic          wr_q, rb_q;
  logic          cap_q, sh_q, wstb_q, upd_q;
  logic [2:0]    sel_q;
  logic          rsp_valid_q, rsp_err_q;

  logic          accept, illegal, so_sel, wbit, last;
  logic [2:0]    sel_req;
  logic [CW-1:0] len;

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign illegal = (req_addr == 2'd3) || (req_wr && req_addr == 2'd2);
  assign sel_req = 3'b001 << req_addr;
  assign len     = CW'(tgt_len(tgt_q, CTRL_LEN, REF_LEN, STAT_LEN));

  always_comb begin
    so_sel = 1'b0;
    case (tgt_q)
      TGT_CTRL: so_sel = sensor_ctrl_so;
      TGT_REF:  so_sel = ref_counter_so;
      TGT_STAT: so_sel = sensor_status_so;
      default:  so_sel = 1'b0;
    endcase
  end

  pm_ctrl_acc_shifter #(.DW(DW), .CW(CW)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .wdata_i   (req_wdata),
    .clr_cnt_i (cap_q),
    .shift_i   (sh_q),
    .sample_i  (sh_q && (!wr_q || rb_q)),
    .so_i      (so_sel),
    .len_i     (len),
    .wbit_o    (wbit),
    .last_o    (last),
    .rdata_o   (rsp_rdata)
  );

  // Reads (and readback passes) recirculate so so the shift stage ends where it started.
  assign serial_in            = sh_q && ((wr_q && !rb_q) ? wbit : so_sel);
  assign capture              = cap_q;
  assign shift                = sh_q;
  assign write                = wstb_q;
  assign update               = upd_q;
  assign sensor_ctrl_select   = sel_q[0];
  assign ref_counter_select   = sel_q[1];
  assign sensor_status_select = sel_q[2];
  assign req_ready            = (state_q == ST_IDLE);
  assign rsp_valid            = rsp_valid_q;
  assign rsp_err              = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tgt_q       <= TGT_CTRL;
      wr_q        <= 1'b0;
      rb_q        <= 1'b0;
      cap_q       <= 1'b0;
      sh_q        <= 1'b0;
      wstb_q      <= 1'b0;
      upd_q       <= 1'b0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      cap_q  <= 1'b0;
      sh_q   <= 1'b0;
      wstb_q <= 1'b0;
      upd_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (req_valid) begin
          wr_q      <= req_wr;
          tgt_q     <= tgt_e'(req_addr);
          rb_q      <= 1'b0;
          rsp_err_q <= 1'b0;
          if (illegal) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else if (req_wr) begin
            state_q <= ST_SHIFT;
            sh_q    <= 1'b1;
            sel_q   <= sel_req;
          end else begin
            state_q <= ST_CAPTURE;
            cap_q   <= 1'b1;
            sel_q   <= sel_req;
          end
        end
        ST_CAPTURE: begin
          state_q <= ST_SHIFT;
          sh_q    <= 1'b1;
        end
        ST_SHIFT: begin
          if (rb_q && (so_sel != wbit))
            rsp_err_q <= 1'b1;
          if (last) begin
            if (wr_q && !rb_q) begin
              state_q <= ST_UPDATE;
              wstb_q  <= 1'b1;
              upd_q   <= 1'b1;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              sel_q       <= '0;
            end
          end else begin
            sh_q <= 1'b1;
          end
        end
        ST_UPDATE: begin
`ifdef PM_ACC_READBACK_EN
          state_q <= ST_CAPTURE;
          cap_q   <= 1'b1;
          rb_q    <= 1'b1;
`else
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          sel_q       <= '0;
`endif
        end
        ST_RESP: if (rsp_ready) begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_ctrl_reg_access_seq.sv
// tb/tb_pm_ctrl_reg_access_seq.sv - directed bench with a serial register model for pm_ctrl_reg_access_seq
module tb_pm_ctrl_reg_access_seq;

`ifdef PM_ACC_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        serial_in, capture, shift, write, update;
  logic        sensor_ctrl_select, ref_counter_select, sensor_status_select;
  logic        sensor_ctrl_so, ref_counter_so, sensor_status_so;

  // Register interface model: parallel register, shift stage, so = stage LSB.
  logic [15:0] reg_ctrl = 16'h0000;
  logic [31:0] reg_ref  = 32'hFFFF_FFFF;
  logic [31:0] reg_stat = 32'h1234_5678;
  logic [15:0] st_ctrl  = 16'h0000;
  logic [31:0] st_ref   = 32'h0;
  logic [31:0] st_stat  = 32'h0;
  logic [15:0] ctrl_log = 16'h0;
  logic [31:0] ref_stuck;

  int tests = 0;
  int fails = 0;
  int ncap, nsh, nupd, nstrobe, lat, nrsp;
  logic [31:0] hold_rdata;

  pm_ctrl_reg_access_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .serial_in(serial_in), .capture(capture), .shift(shift), .write(write), .update(update),
    .sensor_ctrl_select(sensor_ctrl_select), .ref_counter_select(ref_counter_select),
    .sensor_status_select(sensor_status_select),
    .sensor_ctrl_so(sensor_ctrl_so), .ref_counter_so(ref_counter_so),
    .sensor_status_so(sensor_status_so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sensor_ctrl_so   = st_ctrl[0];
  assign ref_counter_so   = st_ref[0];
  assign sensor_status_so = st_stat[0];

  always @(posedge clk) begin
    if (sensor_ctrl_select) begin
      if (capture) st_ctrl <= reg_ctrl;
      if (shift) begin
        st_ctrl  <= {serial_in, st_ctrl[15:1]};
        ctrl_log <= {serial_in, ctrl_log[15:1]};
      end
      if (update && write) reg_ctrl <= st_ctrl;
    end
    if (ref_counter_select) begin
      if (capture) st_ref <= reg_ref;
      if (shift) st_ref <= {serial_in, st_ref[31:1]};
      if (update && write) reg_ref <= st_ref & ~ref_stuck;
    end
    if (sensor_status_select) begin
      if (capture) st_stat <= reg_stat;
      if (shift) st_stat <= {serial_in, st_stat[31:1]};
      if (update && write) reg_stat <= st_stat;
    end
  end

  function automatic logic [8:0] strobes();
    return {capture, shift, write, update, sensor_ctrl_select, ref_counter_select,
            sensor_status_select, serial_in, rsp_valid};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept edge is cycle 1; lat = cycle in which rsp_valid is first seen (0 on timeout).
  task automatic do_req(input logic wr, input logic [1:0] addr, input logic [31:0] wd);
    req_wr = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    ncap = 0; nsh = 0; nupd = 0; nstrobe = 0; lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (n == 1) req_valid = 1'b0;
      if (rsp_valid) begin lat = n; break; end
      ncap += int'(capture);
      nsh  += int'(shift);
      nupd += int'(update && write);
      if (strobes() != 9'b0) nstrobe++;
    end
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, {62'b0, rsp_valid, req_ready}, 64'h1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 2'd0;
    req_wdata = 32'h0; rsp_ready = 1'b0; ref_stuck = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {46'b0, strobes(), rsp_err, rsp_rdata != 32'h0}, 64'h0);
    check("reset_ready", {63'b0, req_ready}, 64'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b0, 2'd1, 32'h0);
    check("rd_ref_lat", lat, 34);
    check("rd_ref_data", rsp_rdata, 32'hFFFF_FFFF);
    check("rd_ref_counts", {ncap[15:0], nsh[15:0], nupd[15:0], 16'h0}, {16'd1, 16'd32, 16'd0, 16'h0});
    check("rd_ref_restored", {st_ref, reg_ref}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    finish_rsp("rd_ref");

    do_req(1'b1, 2'd0, 32'h0000_A5C3);
    check("wr_ctrl_lat", lat, (RB != 0) ? 35 : 18);
    check("wr_ctrl_serial", ctrl_log, 16'hA5C3);
    check("wr_ctrl_reg", reg_ctrl, 16'hA5C3);
    check("wr_ctrl_counts", {nsh[15:0], nupd[15:0]}, {(RB != 0) ? 16'd32 : 16'd16, 16'd1});
    check("wr_ctrl_rsp", {rsp_err, rsp_rdata}, {1'b0, (RB != 0) ? 32'h0000_A5C3 : 32'h0});
    finish_rsp("wr_ctrl");

    do_req(1'b0, 2'd0, 32'h0);
    check("rd_ctrl_lat", lat, 18);
    check("rd_ctrl_data", {rsp_err, rsp_rdata}, {1'b0, 32'h0000_A5C3});
    finish_rsp("rd_ctrl");

    do_req(1'b0, 2'd2, 32'h0);
    check("rd_stat_lat", lat, 34);
    check("rd_stat_data", rsp_rdata, 32'h1234_5678);
    finish_rsp("rd_stat");

    do_req(1'b1, 2'd2, 32'hFFFF_FFFF);
    check("wr_stat_lat", lat, 1);
    check("wr_stat_rsp", {nstrobe[15:0], rsp_err, rsp_rdata}, {16'd0, 1'b1, 32'h0});
    check("wr_stat_reg", reg_stat, 32'h1234_5678);
    finish_rsp("wr_stat");

    do_req(1'b0, 2'd3, 32'h0);
    check("ill_lat", lat, 1);
    check("ill_rsp", {nstrobe[15:0], rsp_err, rsp_rdata}, {16'd0, 1'b1, 32'h0});
    finish_rsp("ill");

    do_req(1'b1, 2'd1, 32'h0F0F_1234);
    check("wr_ref_lat", lat, (RB != 0) ? 67 : 34);
    check("wr_ref_reg", {rsp_err, reg_ref}, {1'b0, 32'h0F0F_1234});
    finish_rsp("wr_ref");

    // Response held off while a new request waits.
    do_req(1'b0, 2'd1, 32'h0);
    check("hold_first", {rsp_err, rsp_rdata}, {1'b0, 32'h0F0F_1234});
    hold_rdata = rsp_rdata;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_stable", {strobes(), req_ready, rsp_rdata}, {9'b0_0000_0001, 1'b0, hold_rdata});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("hold_release", {strobes(), req_ready}, {9'b0, 1'b1});
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("hold_next_acc", {capture, sensor_ctrl_select, req_ready}, 3'b110);
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    check("hold_next_data", {rsp_valid, rsp_rdata}, {1'b1, 32'h0000_A5C3});
    finish_rsp("hold_next");

    // Reset in the middle of a ref write at shift k=7.
    req_wr = 1'b1; req_addr = 2'd1; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (n == 1) req_valid = 1'b0;
    end
    check("mid_shifting", {shift, ref_counter_select}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", {46'b0, strobes(), rsp_err, rsp_rdata != 32'h0}, 64'h0);
    check("mid_reset_ready", {63'b0, req_ready}, 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      nrsp += int'(rsp_valid);
    end
    check("mid_no_rsp", nrsp, 0);
    check("mid_reg_kept", reg_ref, 32'h0F0F_1234);

    do_req(1'b0, 2'd1, 32'h0);
    check("post_rd_lat", lat, 34);
    check("post_rd_data", rsp_rdata, 32'h0F0F_1234);
    finish_rsp("post_rd");

`ifdef PM_ACC_READBACK_EN
    ref_stuck = 32'h0000_0008;
    do_req(1'b1, 2'd1, 32'hDEAD_BEEF);
    check("rb_lat", lat, 67);
    check("rb_rsp", {rsp_err, rsp_rdata}, {1'b1, 32'hDEAD_BEE7});
    finish_rsp("rb");
    ref_stuck = 32'h0;
`else
    do_req(1'b1, 2'd1, 32'hDEAD_BEEF);
    check("wr_ref2_lat", lat, 34);
    check("wr_ref2_rsp", {rsp_err, rsp_rdata}, {1'b0, 32'h0});
    check("wr_ref2_reg", reg_ref, 32'hDEAD_BEEF);
    finish_rsp("wr_ref2");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
